// File: rtl/seq_share_if.sv
// Bundle between the shared-detector scheduler, its requesters
// and the single detector instance.
interface seq_share_if #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 4
);
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  req_bit;
    logic [NREQ-1:0]  bit_rd;
    logic             det_rst;
    logic             det_in;
    logic             det_out;
    logic             busy;
    logic [ID_W-1:0]  gnt_id;
    logic             done;
    logic [ID_W-1:0]  done_id;
    logic [CNT_W-1:0] hit_cnt;
    logic             hit;

    modport master (
        input  req, req_bit, det_out,
        output bit_rd, det_rst, det_in, busy, gnt_id,
        output done, done_id, hit_cnt, hit
    );

    modport slave (
        output req, req_bit, det_out,
        input  bit_rd, det_rst, det_in, busy, gnt_id,
        input  done, done_id, hit_cnt, hit
    );
endinterface

// File: rtl/seq_share_ctrl.sv
// Round-robin frame scheduler time-sharing one serial sequence
// detector among NREQ bit-stream requesters.
module seq_share_ctrl #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 8,
    parameter int ID_W      = 2,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    seq_share_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  base;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  idx;
    logic             found;
    logic             any;
    logic [ID_W-1:0]  gnt_q;
    logic [ID_W-1:0]  done_id_q;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_nx;
    logic [CNT_W-1:0] hit_cnt_q;
    logic             hit_q;
    logic             det_rst_q;
    logic             samp;
    logic             last_bit;
    logic             last_drain;

    assign any = |bus.req;

    // In DONE, last is about to become gnt_q, so search from there.
    assign base = (state == DONE) ? gnt_q : last;

    always_comb begin
        win   = base;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = ID_W'((int'(base) + i) % NREQ);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign last_bit   = (bcnt == CNT_W'(FRAME_LEN - 1));
    assign last_drain = (bcnt == CNT_W'(1));

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (any) nxt = GRANT;
            GRANT:   nxt = SHIFT;
            SHIFT:   if (last_bit) nxt = DRAIN;
            DRAIN:   if (last_drain) nxt = DONE;
            DONE:    nxt = any ? GRANT : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Detector output lags its input by two cycles, so the window
    // skips the first two SHIFT edges and covers both DRAIN edges.
    assign samp = ((state == SHIFT) && (bcnt >= CNT_W'(2)))
                || (state == DRAIN);

    always_comb begin
        acc_nx = acc;
        if (samp && bus.det_out && (acc != '1))
            acc_nx = acc + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= ID_W'(NREQ - 1);
            gnt_q     <= '0;
            done_id_q <= '0;
            bcnt      <= '0;
            acc       <= '0;
            hit_cnt_q <= '0;
            hit_q     <= 1'b0;
            det_rst_q <= 1'b1;
        end else begin
            state     <= nxt;
            det_rst_q <= !((nxt == SHIFT) || (nxt == DRAIN));
            if (state != nxt)
                bcnt <= '0;
            else if ((state == SHIFT) || (state == DRAIN))
                bcnt <= bcnt + CNT_W'(1);
            if (state == GRANT)
                acc <= '0;
            else
                acc <= acc_nx;
            if (nxt == GRANT)
                gnt_q <= win;
            if (state == DONE)
                last <= gnt_q;
            if ((state == DRAIN) && (nxt == DONE)) begin
                done_id_q <= gnt_q;
                hit_cnt_q <= acc_nx;
                hit_q     <= (acc_nx != '0);
            end
        end
    end

    assign bus.det_rst = det_rst_q;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.gnt_id  = gnt_q;
    assign bus.done_id = done_id_q;
    assign bus.hit_cnt = hit_cnt_q;
    assign bus.hit     = hit_q;
    assign bus.bit_rd  = (state == SHIFT) ? (NREQ'(1) << gnt_q) : '0;
    assign bus.det_in  = (state == SHIFT) && bus.req_bit[gnt_q];
endmodule

// File: tb/tb_seq_share_ctrl.sv
// Scoreboard bench for seq_share_ctrl with a behavioural
// three-state detector and per-requester pattern sources.
module tb_seq_share_ctrl;
    localparam int NREQ = 4;
    localparam int FL   = 8;
    localparam int IDW  = 2;
    localparam int CW   = 4;

    typedef struct {
        int id;
        int cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   cyc;
    int   grant_cyc;
    int   n_done;
    int   rd_cnt [NREQ];
    logic busy_q;
    exp_t sb [$];

    logic [7:0]      pat [NREQ];
    logic [2:0]      pos [NREQ];
    logic [NREQ-1:0] rb;
    logic [1:0]      dst;
    logic            dout;

    seq_share_if #(.NREQ(NREQ), .ID_W(IDW), .CNT_W(CW)) bus ();

    seq_share_ctrl #(
        .NREQ(NREQ), .FRAME_LEN(FL), .ID_W(IDW), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Requester sources: bit 1 of a frame is pat[i][7].
    always_comb
        for (int i = 0; i < NREQ; i++)
            rb[i] = pat[i][3'd7 - pos[i]];
    assign bus.req_bit = rb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) pos[i] <= 3'd0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (bus.bit_rd[i]) pos[i] <= pos[i] + 3'd1;
        end
    end

    // Detector: 00 -0-> 01, 00 -1-> 10, 01 holds on 1, 10 absorbing.
    always @(posedge clk) begin
        if (bus.det_rst) begin
            dst  <= 2'b00;
            dout <= 1'b0;
        end else begin
            dout <= (dst == 2'b01);
            case (dst)
                2'b00:   dst <= bus.det_in ? 2'b10 : 2'b01;
                2'b01:   dst <= bus.det_in ? 2'b01 : 2'b10;
                default: dst <= 2'b10;
            endcase
        end
    end
    assign bus.det_out = dout;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_hits(input logic [7:0] p);
        int st = 0;
        int h  = 0;
        for (int k = 7; k >= 0; k--) begin
            if (st == 0)      st = p[k] ? 2 : 1;
            else if (st == 1) st = p[k] ? 1 : 2;
            if (st == 1) h++;
        end
        return h;
    endfunction

    // Monitor: scoreboard pop on done, bit_rd sanity in SHIFT.
    always @(negedge clk) begin
        if (rst) begin
            busy_q = 1'b0;
        end else begin
            if (bus.busy && !busy_q) grant_cyc = cyc;
            busy_q = bus.busy;
            if (bus.bit_rd != '0) begin
                chk("bitrd_onehot", int'($onehot(bus.bit_rd)), 1);
                chk("bitrd_gnt", int'(bus.bit_rd), 1 << bus.gnt_id);
                for (int i = 0; i < NREQ; i++)
                    if (bus.bit_rd[i]) rd_cnt[i]++;
            end
            if (bus.done) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_id", int'(bus.done_id), e.id);
                    chk("hit_cnt", int'(bus.hit_cnt), e.cnt);
                    chk("hit", int'(bus.hit), int'(e.cnt != 0));
                end
            end
        end
    end

    task automatic wait_done(input int lim);
        logic got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk);
            got = bus.done;
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_busy(input int lim);
        logic got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk);
            got = bus.busy;
        end
        if (!got) chk("busy_timeout", 0, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_det_rst"}, int'(bus.det_rst), 1);
        chk({tag, "_det_in"},  int'(bus.det_in), 0);
        chk({tag, "_bit_rd"},  int'(bus.bit_rd), 0);
        chk({tag, "_busy"},    int'(bus.busy), 0);
        chk({tag, "_gnt_id"},  int'(bus.gnt_id), 0);
        chk({tag, "_done"},    int'(bus.done), 0);
        chk({tag, "_done_id"}, int'(bus.done_id), 0);
        chk({tag, "_hit_cnt"}, int'(bus.hit_cnt), 0);
        chk({tag, "_hit"},     int'(bus.hit), 0);
    endtask

    initial begin
        int ids [5];
        int prev;
        int d0;
        int r0;
        n_chk = 0;
        n_err = 0;
        cyc = 0;
        n_done = 0;
        grant_cyc = 0;
        for (int i = 0; i < NREQ; i++) begin
            pat[i] = 8'h00;
            rd_cnt[i] = 0;
        end
        rst = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);

        // Single requester, all-ones tail: every sample hits.
        pat[0] = 8'b0111_1111;
        sb.push_back('{id: 0, cnt: 8});
        bus.req = 4'b0001;
        wait_done(40);
        chk("latency", cyc - grant_cyc, 11);
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_det_rst", int'(bus.det_rst), 1);
        chk("hold_hit_cnt", int'(bus.hit_cnt), 8);
        chk("hold_done_id", int'(bus.done_id), 0);

        pat[2] = 8'b0110_1111;
        sb.push_back('{id: 2, cnt: 3});
        bus.req = 4'b0100;
        wait_done(40);
        bus.req = '0;
        repeat (2) @(negedge clk);

        pat[3] = 8'b1000_0000;
        sb.push_back('{id: 3, cnt: 0});
        bus.req = 4'b1000;
        wait_done(40);
        bus.req = '0;
        repeat (2) @(negedge clk);

        // All four requesting: round robin 0,1,2,3,0.
        pat[0] = 8'b0011_1100;
        pat[1] = 8'b0101_0101;
        pat[2] = 8'b0000_0000;
        pat[3] = 8'b0111_1110;
        ids = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++)
            sb.push_back('{id: ids[k], cnt: exp_hits(pat[ids[k]])});
        bus.req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_done(40);
            if (k > 0) chk("rr_gap", cyc - prev, 12);
            prev = cyc;
            if (k > 0) bus.req[ids[k]] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rr_idle", int'(bus.busy), 0);

        // req dropped mid-frame: the frame still runs to completion.
        pat[1] = 8'b0111_0111;
        r0 = rd_cnt[1];
        d0 = n_done;
        sb.push_back('{id: 1, cnt: exp_hits(pat[1])});
        bus.req = 4'b0010;
        wait_busy(10);
        repeat (4) @(negedge clk);
        bus.req = '0;
        wait_done(40);
        repeat (4) @(negedge clk);
        chk("drop_bitrd", rd_cnt[1] - r0, 8);
        chk("drop_dones", n_done - d0, 1);

        // Reset in SHIFT cycle 5 aborts the frame silently.
        pat[0] = 8'b0110_1111;
        d0 = n_done;
        bus.req = 4'b0001;
        wait_busy(10);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        chk("abort_det_rst", int'(bus.det_rst), 1);
        rst = 1'b0;
        chk("abort_no_done", n_done - d0, 0);
        sb.push_back('{id: 0, cnt: 3});
        wait_done(40);
        chk("post_rst_gnt", int'(bus.gnt_id), 0);
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
